// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and load/store.
// LS has priority; a starvation counter forces an IF win, and flush kills an in-flight fetch.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | no transaction; arbitrate IF/LS and latch the winner into mem_*
// ISSUE  | mem_req high with mem_* stable until mem_gnt
// WAIT   | granted; waiting for mem_rvalid, read data captured on arrival
// RESP   | owner's done pulses this cycle (unless the fetch was killed)
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_done,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CTR_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CTR_W-1:0] LIMIT = CTR_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              kill_q, kill_d;
  logic [CTR_W-1:0]  starve_q, starve_d;
  logic              mem_we_q, mem_we_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

  logic if_win;
  logic ls_win;
  logic if_flushed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      kill_q      <= 1'b0;
      starve_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      kill_q      <= kill_d;
      starve_q    <= starve_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  // Flush blocks IF in IDLE for that cycle only; LS wins ties unless IF has starved.
  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (state_q == S_IDLE) begin
      if (if_req && !flush && (!ls_req || (starve_q == LIMIT))) begin
        if_win = 1'b1;
      end else if (ls_req) begin
        ls_win = 1'b1;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (flush || !if_req || if_win) begin
      starve_d = '0;
    end else if (ls_win && (starve_q != LIMIT)) begin
      starve_d = starve_q + CTR_W'(1);
    end
  end

  assign if_flushed = flush && (owner_q == OWN_IF);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    kill_d      = kill_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;

    case (state_q)
      S_IDLE: begin
        // A fetch always reads the full word.
        if (if_win) begin
          owner_d     = OWN_IF;
          mem_we_d    = 1'b0;
          mem_be_d    = '1;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          state_d     = S_ISSUE;
        end else if (ls_win) begin
          owner_d     = OWN_LS;
          mem_we_d    = ls_we;
          mem_be_d    = ls_be;
          mem_addr_d  = ls_addr;
          mem_wdata_d = ls_wdata;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (if_flushed) kill_d = 1'b1;
        if (mem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (if_flushed) kill_d = 1'b1;
        if (mem_rvalid) begin
          state_d = S_RESP;
          if ((owner_q == OWN_IF) && !kill_q && !flush) begin
            if_rdata_d = mem_rdata;
          end
          if ((owner_q == OWN_LS) && !mem_we_q) begin
            ls_rdata_d = mem_rdata;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
        kill_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
        kill_d  = 1'b0;
      end
    endcase
  end

  assign mem_req   = (state_q == S_ISSUE);
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

  assign if_done = !if_req
                 || ((state_q == S_RESP) && (owner_q == OWN_IF) && !kill_q && !flush);
  assign ls_done = !ls_req || ((state_q == S_RESP) && (owner_q == OWN_LS));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_done;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        auto_mem, rand_mem;
  logic        man_gnt, man_rvalid;
  logic [31:0] man_rdata;
  logic        a_gnt, a_rvalid;
  logic [31:0] a_rdata;
  logic        cmp_en;
  int          n_chk, n_pass;

  assign mem_gnt    = auto_mem ? a_gnt    : man_gnt;
  assign mem_rvalid = auto_mem ? a_rvalid : man_rvalid;
  assign mem_rdata  = auto_mem ? a_rdata  : man_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level reference model ----------------
  logic        m_busy, m_isif, m_gr, m_resp, m_kill, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_ifd, m_lsd;
  int          m_starve;

  task automatic model_step();
    logic iw, lw;
    iw = 1'b0;
    lw = 1'b0;
    if (rst) begin
      m_busy = 0; m_isif = 0; m_gr = 0; m_resp = 0; m_kill = 0;
      m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0; m_ifd = 0; m_lsd = 0;
      m_starve = 0;
      return;
    end
    if (!m_busy) begin
      if (if_req && !flush && (!ls_req || m_starve == LIMIT)) iw = 1'b1;
      else if (ls_req) lw = 1'b1;
    end
    if (flush || !if_req || iw) m_starve = 0;
    else if (lw && m_starve < LIMIT) m_starve++;
    if (iw) begin
      m_busy = 1; m_isif = 1; m_gr = 0; m_resp = 0; m_kill = 0;
      m_addr = if_addr; m_we = 0; m_be = 4'hF; m_wdata = 0;
    end else if (lw) begin
      m_busy = 1; m_isif = 0; m_gr = 0; m_resp = 0; m_kill = 0;
      m_addr = ls_addr; m_we = ls_we; m_be = ls_be; m_wdata = ls_wdata;
    end else if (m_busy && m_resp) begin
      m_busy = 0; m_resp = 0; m_gr = 0; m_kill = 0;
    end else if (m_busy) begin
      if (m_gr && mem_rvalid) begin
        if (m_isif && !m_kill && !flush) m_ifd = mem_rdata;
        if (!m_isif && !m_we) m_lsd = mem_rdata;
        m_resp = 1;
      end
      if (!m_gr && mem_gnt) m_gr = 1;
      if (flush && m_isif) m_kill = 1;
    end
  endtask

  always begin
    @(posedge clk);
    model_step();
  end

  always begin
    @(negedge clk);
    if (cmp_en) begin
      chk("mem_req",   mem_req,   m_busy && !m_gr);
      chk("mem_we",    mem_we,    m_we);
      chk("mem_be",    mem_be,    m_be);
      chk("mem_addr",  mem_addr,  m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("if_done",   if_done,   !if_req || (m_busy && m_resp && m_isif && !m_kill && !flush));
      chk("ls_done",   ls_done,   !ls_req || (m_busy && m_resp && !m_isif));
      chk("if_rdata",  if_rdata,  m_ifd);
      chk("ls_rdata",  ls_rdata,  m_lsd);
    end
  end

  // ---------------- memory responder (auto mode) ----------------
  logic rs, pend;
  int   wait_n;
  always begin
    @(posedge clk);
    rs = rst;
    #1;
    if (!auto_mem || rs) begin
      pend = 0; a_gnt = 0; a_rvalid = 0;
    end else begin
      a_rvalid = 0;
      if (pend) begin
        wait_n--;
        if (wait_n == 0) begin
          a_rvalid = 1; a_rdata = $urandom; pend = 0;
        end
      end
      a_gnt = 0;
      if (mem_req && !pend && !a_rvalid && (!rand_mem || $urandom_range(0, 2) != 0)) begin
        a_gnt = 1; pend = 1;
        wait_n = rand_mem ? int'($urandom_range(1, 3)) : 1;
      end
    end
  end

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int ls_t, if_t, ls_cnt, if_n, c;
    logic if_dn, ls_dn;
    n_chk = 0; n_pass = 0; cmp_en = 0;
    rst = 1; flush = 0; if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0;
    ls_be = 0; ls_addr = 0; ls_wdata = 0;
    auto_mem = 0; rand_mem = 0; man_gnt = 0; man_rvalid = 0; man_rdata = 0;
    a_gnt = 0; a_rvalid = 0; a_rdata = 0; pend = 0; wait_n = 0;
    tick();
    cmp_en = 1;
    tick();
    rst = 0;
    #3;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_done", if_done, 1);
    chk("rst_ls_done", ls_done, 1);
    chk("rst_mem_addr", mem_addr, 0);
    tick();

    // Single load: mem_req only in cycle 1, ls_done in cycle 3.
    ls_req = 1; ls_addr = 32'h100; ls_we = 0; ls_be = 4'hF;
    #3; chk("t1_c0_mem_req", mem_req, 0); chk("t1_c0_ls_done", ls_done, 0); tick();
    man_gnt = 1;
    #3; chk("t1_c1_mem_req", mem_req, 1); chk("t1_c1_mem_addr", mem_addr, 32'h100); tick();
    man_gnt = 0; man_rvalid = 1; man_rdata = 32'hDEADBEEF;
    #3; chk("t1_c2_mem_req", mem_req, 0); chk("t1_c2_ls_done", ls_done, 0); tick();
    man_rvalid = 0;
    #3; chk("t1_c3_ls_done", ls_done, 1); chk("t1_c3_ls_rdata", ls_rdata, 32'hDEADBEEF); tick();
    ls_req = 0;
    #3; tick();

    // IF and LS together, 1-cycle memory; the LS is a store.
    auto_mem = 1; rand_mem = 0;
    if_req = 1; if_addr = 32'h200;
    ls_req = 1; ls_addr = 32'h300; ls_we = 1; ls_be = 4'h3; ls_wdata = 32'hA5A5;
    ls_t = -1; if_t = -1;
    for (int k = 0; k < 30; k++) begin
      #3;
      if (ls_req && ls_done && ls_t < 0) ls_t = k;
      if (if_req && if_done && if_t < 0) if_t = k;
      if (k == 1) begin
        chk("t2_mem_we", mem_we, 1); chk("t2_mem_be", mem_be, 4'h3);
        chk("t2_mem_wdata", mem_wdata, 32'hA5A5); chk("t2_mem_addr", mem_addr, 32'h300);
      end
      tick();
      if (ls_t >= 0) ls_req = 0;
      if (if_t >= 0) if_req = 0;
    end
    chk("t2_ls_done_cycle", ls_t, 3);
    chk("t2_if_done_cycle", if_t, 7);
    chk("t2_store_keeps_ls_rdata", ls_rdata, 32'hDEADBEEF);

    // Reset while in WAIT; a late rvalid must be ignored.
    auto_mem = 0;
    tick();
    ls_req = 1; ls_we = 0; ls_addr = 32'h10; ls_be = 4'hF;
    #3; tick();
    man_gnt = 1;
    #3; chk("t6_c1_mem_req", mem_req, 1); tick();
    man_gnt = 0; rst = 1;
    #3; tick();
    rst = 0; ls_req = 0;
    #3;
    chk("t6_mem_req", mem_req, 0); chk("t6_mem_addr", mem_addr, 0);
    chk("t6_mem_be", mem_be, 0); chk("t6_ls_rdata", ls_rdata, 0);
    chk("t6_if_rdata", if_rdata, 0); chk("t6_ls_done", ls_done, 1);
    tick();
    man_rvalid = 1; man_rdata = 32'hFFFF;
    #3; tick();
    man_rvalid = 0;
    #3; chk("t6_late_rdata", ls_rdata, 0); chk("t6_late_mem_req", mem_req, 0); tick();

    // Continuous LS stream with IF held: IF wins the 5th arbitration, twice in a row.
    do_reset();
    auto_mem = 1; rand_mem = 0;
    if_req = 1; if_addr = 32'h1000; ls_req = 1; ls_we = 0; ls_addr = 32'h2000;
    ls_cnt = 0; if_n = 0; c = 0;
    while (if_n < 2 && c < 120) begin
      #3;
      ls_dn = ls_req && ls_done;
      if_dn = if_req && if_done;
      if (ls_dn) ls_cnt++;
      if (if_dn) begin
        if_n++;
        chk("t3_ls_wins_before_if", ls_cnt, 4);
        if (if_n == 1) chk("t3_first_if_done_cycle", c, 19);
        ls_cnt = 0;
      end
      tick();
      c++;
      if (ls_dn) ls_addr = ls_addr + 4;
      if (if_dn) if_addr = if_addr + 4;
    end
    chk("t3_if_done_count", if_n, 2);
    if_req = 0; ls_req = 0;
    tick(); tick();

    // Flush during IF WAIT, rvalid 3 cycles late.
    auto_mem = 0;
    do_reset();
    if_req = 1; if_addr = 32'h40;
    #3; tick();
    man_gnt = 1;
    #3; chk("t4_c1_mem_req", mem_req, 1); tick();
    man_gnt = 0; flush = 1; if_addr = 32'h44;
    #3; chk("t4_c2_if_done", if_done, 0); tick();
    flush = 0;
    #3; tick();
    #3; tick();
    man_rvalid = 1; man_rdata = 32'h1234;
    #3; tick();
    man_rvalid = 0;
    #3; chk("t4_killed_if_done", if_done, 0); chk("t4_killed_if_rdata", if_rdata, 0); tick();
    #3; chk("t4_c7_mem_req", mem_req, 0); tick();
    man_gnt = 1;
    #3; chk("t4_c8_mem_req", mem_req, 1); chk("t4_c8_mem_addr", mem_addr, 32'h44); tick();
    man_gnt = 0; man_rvalid = 1; man_rdata = 32'h5678;
    #3; tick();
    man_rvalid = 0;
    #3; chk("t4_next_if_done", if_done, 1); chk("t4_next_if_rdata", if_rdata, 32'h5678); tick();
    if_req = 0;
    #3; tick();

    // Grant withheld 5 cycles, flush in cycle 2: mem_req held, response dropped.
    do_reset();
    if_req = 1; if_addr = 32'h80;
    #3; tick();
    for (int k = 1; k <= 5; k++) begin
      flush = (k == 2);
      if (k == 2) if_addr = 32'h90;
      #3;
      chk("t5_mem_req_held", mem_req, 1);
      chk("t5_mem_addr_held", mem_addr, 32'h80);
      tick();
    end
    flush = 0; man_gnt = 1;
    #3; chk("t5_c6_mem_req", mem_req, 1); tick();
    man_gnt = 0; man_rvalid = 1; man_rdata = 32'hBAD;
    #3; tick();
    man_rvalid = 0;
    #3; chk("t5_dropped_if_done", if_done, 0); chk("t5_dropped_if_rdata", if_rdata, 0); tick();
    #3; tick();
    #3; chk("t5_reissue_mem_req", mem_req, 1); chk("t5_reissue_addr", mem_addr, 32'h90); tick();
    if_req = 0;
    #3; tick();

    // Randomized traffic against the model.
    auto_mem = 1; rand_mem = 1;
    if_dn = 0; ls_dn = 0;
    for (int k = 0; k < 3000; k++) begin
      flush = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 299) == 0);
      if (if_req) begin
        if (if_dn) begin
          if ($urandom_range(0, 1) == 1) if_req = 0;
          else if_addr = $urandom & 32'hFFFC;
        end else if (flush) if_addr = $urandom & 32'hFFFC;
        else if ($urandom_range(0, 49) == 0) if_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom & 32'hFFFC;
      end
      if (ls_req && !ls_dn) begin
        if ($urandom_range(0, 49) == 0) ls_req = 0;
      end else if (ls_dn && $urandom_range(0, 1) == 1) begin
        ls_req = 0;
      end else if (ls_dn || $urandom_range(0, 2) == 0) begin
        ls_req = 1; ls_we = $urandom_range(0, 1); ls_be = 4'($urandom);
        ls_addr = $urandom & 32'hFFFC; ls_wdata = $urandom;
      end
      #3;
      if_dn = if_req && if_done;
      ls_dn = ls_req && ls_done;
      tick();
    end
    rst = 0; flush = 0; if_req = 0; ls_req = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
